// File: rtl/gamemachine_pkg.sv
// Shared types and constants for the two-player digit-guessing game.
package gamemachine_pkg;

  typedef enum logic [1:0] {
    P1_ENTRY = 2'd0,
    P2_ENTRY = 2'd1,
    SCORE    = 2'd2,
    DONE     = 2'd3
  } gm_state_e;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = 4;
  localparam int CNT_W      = $clog2(NUM_DIGITS);

  localparam logic [SCORE_W-1:0] EXACT_PTS = 4'd2;
  localparam logic [SCORE_W-1:0] NEAR_PTS  = 4'd1;
  localparam logic [SCORE_W-1:0] TOTAL_PTS = 4'd8;

endpackage

// File: rtl/gm_scorer.sv
// Combinational per-position scorer: exact hit 2 points, digit present
// elsewhere in the secret 1 point, no one-to-one matching.
module gm_scorer
  import gamemachine_pkg::*;
#(
  parameter int DIGIT_W = 3
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret_i,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess_i,
  output logic [SCORE_W-1:0]            score2_o
);

  logic near;

  always_comb begin
    score2_o = '0;
    near     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      near = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (guess_i[i*DIGIT_W +: DIGIT_W] ==
            secret_i[j*DIGIT_W +: DIGIT_W])
          near = 1'b1;
      end
      if (guess_i[i*DIGIT_W +: DIGIT_W] ==
          secret_i[i*DIGIT_W +: DIGIT_W])
        score2_o = score2_o + EXACT_PTS;
      else if (near)
        score2_o = score2_o + NEAR_PTS;
    end
  end

endmodule

// File: rtl/game_machine.sv
// Game FSM, digit registers and registered score outputs.
// GAMEMACHINE_EDGE_DETECT_EN selects rising-edge strobe detection.
module game_machine
  import gamemachine_pkg::*;
#(
  parameter int DIGIT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter1,
  input  logic               enter2,
  input  logic [DIGIT_W-1:0] dataIn,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2
);

  gm_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] secret_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] guess_q;
  logic [SCORE_W-1:0] score1_q, score2_q;
  logic [SCORE_W-1:0] calc2;
  logic acc1, acc2;
  logic wr_sec, wr_gue, ld_score;

`ifdef GAMEMACHINE_EDGE_DETECT_EN
  logic e1_q, e2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_q <= 1'b0;
      e2_q <= 1'b0;
    end else begin
      e1_q <= enter1;
      e2_q <= enter2;
    end
  end

  assign acc1 = enter1 & ~e1_q;
  assign acc2 = enter2 & ~e2_q;
`else
  assign acc1 = enter1;
  assign acc2 = enter2;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_sec   = 1'b0;
    wr_gue   = 1'b0;
    ld_score = 1'b0;
    unique case (state_q)
      P1_ENTRY: if (acc1) begin
        wr_sec = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = P2_ENTRY;
      end
      P2_ENTRY: if (acc2) begin
        wr_gue = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST)
          state_d = SCORE;
      end
      SCORE: begin
        ld_score = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = P1_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= P1_ENTRY;
      cnt_q    <= '0;
      secret_q <= '0;
      guess_q  <= '0;
      score1_q <= '0;
      score2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_sec)
        secret_q[cnt_q] <= dataIn;
      if (wr_gue)
        guess_q[cnt_q] <= dataIn;
      if (ld_score) begin
        score2_q <= calc2;
        score1_q <= TOTAL_PTS - calc2;
      end
    end
  end

  gm_scorer #(
    .DIGIT_W (DIGIT_W)
  ) u_scorer (
    .secret_i (secret_q),
    .guess_i  (guess_q),
    .score2_o (calc2)
  );

  assign score1 = score1_q;
  assign score2 = score2_q;

endmodule

// File: tb/tb_game_machine.sv
// Self-checking bench for game_machine: behavioural model checked
// every cycle plus directed games with literal expected scores.
module tb_game_machine;

  typedef int quad_t [4];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enter1 = 1'b0;
  logic       enter2 = 1'b0;
  logic [2:0] dataIn = '0;
  logic [3:0] score1, score2;

  int errors = 0;
  int checks = 0;

  game_machine #(.DIGIT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .enter1 (enter1),
    .enter2 (enter2),
    .dataIn (dataIn),
    .score1 (score1),
    .score2 (score2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scoring from the rules: exact=2, digit present anywhere=1
  function automatic int model_score(quad_t s, quad_t g);
    bit present [8];
    int pts = 0;
    for (int d = 0; d < 8; d++) present[d] = 1'b0;
    for (int j = 0; j < 4; j++) present[s[j]] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (g[i] == s[i]) pts += 2;
      else if (present[g[i]]) pts += 1;
    end
    return pts;
  endfunction

  // Behavioural model: phase 0 = collecting secret, 1 = guess,
  // 2 = scoring pending, 3 = finished.
  quad_t msec, mgue;
  int phase = 0, n = 0, m1 = 0, m2 = 0;
  bit pend = 0, started = 0, p1 = 0, p2 = 0, a1, a2;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; n = 0; m1 = 0; m2 = 0;
      pend = 0; p1 = 0; p2 = 0; started = 1;
      msec = '{0, 0, 0, 0};
      mgue = '{0, 0, 0, 0};
    end else begin
`ifdef GAMEMACHINE_EDGE_DETECT_EN
      a1 = enter1 && !p1;
      a2 = enter2 && !p2;
`else
      a1 = enter1;
      a2 = enter2;
`endif
      if (pend) begin
        m2 = model_score(msec, mgue);
        m1 = 8 - m2;
        pend = 0;
        phase = 3;
      end else if (phase == 0 && a1) begin
        msec[n] = int'(dataIn);
        n++;
        if (n == 4) begin n = 0; phase = 1; end
      end else if (phase == 1 && a2) begin
        mgue[n] = int'(dataIn);
        n++;
        if (n == 4) begin n = 0; phase = 2; pend = 1; end
      end
      p1 = enter1;
      p2 = enter2;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_s1", int'(score1), m1);
      check("model_s2", int'(score2), m2);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic pulse(input int which, input int val);
    @(posedge clk); #2;
    dataIn = 3'(val);
    if (which == 1) enter1 = 1'b1;
    else enter2 = 1'b1;
    @(posedge clk); #2;
    enter1 = 1'b0;
    enter2 = 1'b0;
  endtask

  task automatic enter_code(input int which, input quad_t q);
    for (int i = 0; i < 4; i++) pulse(which, q[i]);
  endtask

  task automatic game(input string name, input quad_t s, input quad_t g,
                      input int e1, input int e2);
    do_reset();
    enter_code(1, s);
    enter_code(2, g);
    check({name, "_lat_s2"}, int'(score2), 0);
    cyc(3);
    check({name, "_s1"}, int'(score1), e1);
    check({name, "_s2"}, int'(score2), e2);
  endtask

  initial begin
    do_reset();
    #1;
    check("reset_s1", int'(score1), 0);
    check("reset_s2", int'(score2), 0);

    game("g0124", '{0,1,2,3}, '{0,1,2,4}, 2, 6);
    game("g0132", '{0,1,2,3}, '{0,1,3,2}, 2, 6);
    game("g1043", '{0,1,2,3}, '{1,0,4,3}, 4, 4);
    game("g4567", '{0,1,2,3}, '{4,5,6,7}, 8, 0);
    game("g0025", '{0,1,2,3}, '{0,0,2,5}, 3, 5);
    game("s0011_g0123", '{0,0,1,1}, '{0,1,2,3}, 5, 3);
    game("s0011_g0101", '{0,0,1,1}, '{0,1,0,1}, 2, 6);
    game("g1001", '{0,1,2,3}, '{1,0,0,1}, 4, 4);

    pulse(1, 7); pulse(2, 7); pulse(1, 0); pulse(2, 1);
    cyc(2);
    check("done_hold_s1", int'(score1), 4);
    check("done_hold_s2", int'(score2), 4);

    // enter2 during player-1 entry must be ignored
    do_reset();
    enter_code(2, '{0,1,2,3});
    enter_code(1, '{0,1,2,3});
    check("p1ign_mid_s2", int'(score2), 0);
    enter_code(2, '{4,5,6,7});
    cyc(3);
    check("p1ign_s1", int'(score1), 8);
    check("p1ign_s2", int'(score2), 0);

`ifdef GAMEMACHINE_EDGE_DETECT_EN
    do_reset();
    @(posedge clk); #2 dataIn = 3'd5; enter1 = 1'b1;
    cyc(3);
    enter1 = 1'b0;
    pulse(1, 1); pulse(1, 2); pulse(1, 3);
    enter_code(2, '{5,1,2,3});
    cyc(3);
    check("hold_s1", int'(score1), 0);
    check("hold_s2", int'(score2), 8);
`endif

    // reset in the middle of player-2 entry
    do_reset();
    enter_code(1, '{4,5,6,7});
    pulse(2, 4); pulse(2, 5);
    do_reset();
    #1;
    check("midrst_s1", int'(score1), 0);
    check("midrst_s2", int'(score2), 0);
    enter_code(1, '{0,1,2,3});
    enter_code(2, '{0,1,2,3});
    cyc(3);
    check("after_rst_s1", int'(score1), 0);
    check("after_rst_s2", int'(score2), 8);

    check("model_pin_a", model_score('{0,1,2,3}, '{0,0,2,5}), 5);
    check("model_pin_b", model_score('{0,0,1,1}, '{0,1,0,1}), 6);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
